vdec_hs_crc_ctrl: RTL and testbench

Sequencing controller for the serial HS CRC16 check (generator x^16+x^12+x^5+1, LFSR form with crc_in XORed into bit 0 and feedback from bit 15). It sits after the Viterbi decoder output. It accepts a block descriptor, then feeds decoded payload bits one per valid cycle through the CRC16 next-state function, and compares the received 16 parity bits against the computed remainder. It reports a one-cycle done pulse with a pass/fail flag to the HS control logic.

---
 rtl/vdec_hs_crc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vdec_hs_crc_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vdec_hs_crc_ctrl.sv
// rtl/vdec_hs_crc_ctrl.sv - serial HS CRC16 check sequencer after the Viterbi decoder
//
// Accepts a block descriptor, runs each decoded payload bit through the CRC16
// (x^16+x^12+x^5+1) next-state function, then compares the 16 received parity
// bits, MSB first, against the computed remainder.
//
// Optional feature macro: VDEC_HS_UEID_MASK_EN (UE-identity masking of the parity bits).
//
// Ports:
//   clk        core clock
//   rst_n      synchronous active-low reset
//   blk_start  one-cycle pulse, latches blk_len (and ue_id) and starts a block
//   blk_len    payload bit count, parity excluded
//   ue_id      UE identity for parity masking (VDEC_HS_UEID_MASK_EN only)
//   bit_vld    decoded bit valid
//   bit_in     decoded bit: payload first, then parity MSB first
//   busy       block in progress (DATA or PAR)
//   crc_done   one-cycle end-of-block pulse
//   crc_ok     check result, held until the next blk_start
//   crc_val    computed remainder, held

module vdec_hs_crc_ctrl #(
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_start,
    input  logic [LEN_W-1:0] blk_len,
`ifdef VDEC_HS_UEID_MASK_EN
    input  logic [15:0]      ue_id,
`endif
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             busy,
    output logic             crc_done,
    output logic             crc_ok,
    output logic [15:0]      crc_val
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] PAR_BITS = LEN_W'(16);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [15:0]      crc_reg;
    logic [15:0]      crc_hold;
    logic [15:0]      crc_val_q;
    logic             crc_ok_q;
    logic             mis;
    logic             last_cnt;
    logic             exp_bit;
    logic             par_err;
    logic [15:0]      crc_data_nxt;
    state_t           start_state;

`ifdef VDEC_HS_UEID_MASK_EN
    // Shifted left alongside crc_reg so bit 15 always lines up with parity bit k.
    logic [15:0]      ue_q;
`endif

    // Division-form LFSR: the incoming bit enters bit 0, bit 15 feeds back
    // into the polynomial taps.
    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
        return {c[14:0], b} ^ (c[15] ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_data_nxt = crc_next(crc_reg, bit_in);
    assign last_cnt     = (cnt == ONE);
    assign start_state  = (blk_len == '0) ? PAR : DATA;

`ifdef VDEC_HS_UEID_MASK_EN
    assign exp_bit = crc_reg[15] ^ ue_q[15];
`else
    assign exp_bit = crc_reg[15];
`endif
    assign par_err = bit_in ^ exp_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // blk_start restarts from any state, aborting an in-flight block silently.
    always_comb begin
        state_nxt = state;
        if (blk_start) begin
            state_nxt = start_state;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                DATA: if (bit_vld && last_cnt) state_nxt = PAR;
                PAR:  if (bit_vld && last_cnt) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            crc_reg   <= 16'h0000;
            crc_hold  <= 16'h0000;
            crc_val_q <= 16'h0000;
            crc_ok_q  <= 1'b0;
            mis       <= 1'b0;
`ifdef VDEC_HS_UEID_MASK_EN
            ue_q      <= 16'h0000;
`endif
        end else if (blk_start) begin
            // An empty payload goes straight to PAR, so the parity count is loaded directly.
            cnt      <= (blk_len == '0) ? PAR_BITS : blk_len;
            crc_reg  <= 16'h0000;
            crc_hold <= 16'h0000;
            mis      <= 1'b0;
            crc_ok_q <= 1'b0;
`ifdef VDEC_HS_UEID_MASK_EN
            ue_q     <= ue_id;
`endif
        end else if (bit_vld) begin
            case (state)
                DATA: begin
                    crc_reg  <= crc_data_nxt;
                    crc_hold <= crc_data_nxt;
                    cnt      <= last_cnt ? PAR_BITS : (cnt - ONE);
                end
                PAR: begin
                    mis     <= mis | par_err;
                    crc_reg <= {crc_reg[14:0], 1'b0};
`ifdef VDEC_HS_UEID_MASK_EN
                    ue_q    <= {ue_q[14:0], 1'b0};
`endif
                    cnt     <= cnt - ONE;
                    if (last_cnt) begin
                        // Include the final bit's mismatch, which mis has not absorbed yet.
                        crc_ok_q  <= ~(mis | par_err);
                        crc_val_q <= crc_hold;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == DATA) || (state == PAR);
    assign crc_done = (state == DONE);
    assign crc_ok   = crc_ok_q;
    assign crc_val  = crc_val_q;

endmodule

// File: tb/tb_vdec_hs_crc_ctrl.sv
// tb/tb_vdec_hs_crc_ctrl.sv - scoreboard bench for vdec_hs_crc_ctrl
module tb_vdec_hs_crc_ctrl;

    localparam int LEN_W = 13;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             blk_start = 1'b0;
    logic [LEN_W-1:0] blk_len   = '0;
`ifdef VDEC_HS_UEID_MASK_EN
    logic [15:0]      ue_id     = 16'h0000;
`endif
    logic             bit_vld   = 1'b0;
    logic             bit_in    = 1'b0;
    logic             busy;
    logic             crc_done;
    logic             crc_ok;
    logic [15:0]      crc_val;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic        ok;
        logic [15:0] val;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    vdec_hs_crc_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_start (blk_start),
        .blk_len   (blk_len),
`ifdef VDEC_HS_UEID_MASK_EN
        .ue_id     (ue_id),
`endif
        .bit_vld   (bit_vld),
        .bit_in    (bit_in),
        .busy      (busy),
        .crc_done  (crc_done),
        .crc_ok    (crc_ok),
        .crc_val   (crc_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (crc_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(crc_done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_ok"},    32'(crc_ok),  32'(mon_e.ok));
                check({mon_e.name, "_val"},   32'(crc_val), 32'(mon_e.val));
                check({mon_e.name, "_cycle"}, 32'(cyc),     32'(mon_e.at));
                check({mon_e.name, "_busy"},  32'(busy),    32'd0);
            end
        end
    end

    // Payload bit i is pay[len-1-i]; parity goes MSB first. toggle inserts an
    // idle cycle before every bit but the first. abort_at >= 0 stops after that
    // many bits and expects no done pulse.
    task automatic send_block(input string name, input int len, input logic [31:0] pay,
                              input logic [15:0] par, input bit toggle, input int abort_at,
                              input logic exp_ok, input logic [15:0] exp_val);
        int   total;
        int   idles;
        exp_t e;
        total = len + 16;
        idles = toggle ? total - 1 : 0;
        @(posedge clk); #1;
        blk_start = 1'b1;
        blk_len   = LEN_W'(len);
        bit_vld   = 1'b0;
        if (abort_at < 0) begin
            e.ok   = exp_ok;
            e.val  = exp_val;
            e.at   = cyc + len + 17 + idles;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        blk_start = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        for (int i = 0; i < total; i++) begin
            if (i == abort_at) begin
                bit_vld = 1'b0;
                return;
            end
            if (toggle && i > 0) begin
                bit_vld = 1'b0;
                @(posedge clk); #1;
            end
            bit_vld = 1'b1;
            bit_in  = (i < len) ? pay[len-1-i] : par[15-(i-len)];
            @(posedge clk); #1;
        end
        bit_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_crc_done", 32'(crc_done), 32'd0);
        check("rst_crc_ok",   32'(crc_ok),   32'd0);
        check("rst_crc_val",  32'(crc_val),  32'h0);
        rst_n = 1'b1;

        send_block("zero8",    8,  32'h0,     16'h0000, 1'b0, -1, 1'b1, 16'h0000);
        send_block("p1021",    17, 32'h10000, 16'h1021, 1'b0, -1, 1'b1, 16'h1021);
        send_block("bad1020",  17, 32'h10000, 16'h1020, 1'b0, -1, 1'b0, 16'h1021);
        send_block("p8000",    16, 32'h8000,  16'h8000, 1'b0, -1, 1'b1, 16'h8000);
        send_block("len1",     1,  32'h1,     16'h0001, 1'b0, -1, 1'b1, 16'h0001);
        send_block("toggle",   17, 32'h10000, 16'h1021, 1'b1, -1, 1'b1, 16'h1021);
        send_block("len0",     0,  32'h0,     16'h0000, 1'b0, -1, 1'b1, 16'h0000);

        send_block("abort_old", 17, 32'h10000, 16'h1021, 1'b0, 20, 1'b0, 16'h0000);
        send_block("abort_new", 16, 32'h8000,  16'h8000, 1'b0, -1, 1'b1, 16'h8000);

        send_block("rst_old",  17, 32'h10000, 16'h1021, 1'b0, 5, 1'b0, 16'h0000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_crc_done", 32'(crc_done), 32'd0);
        check("midrst_crc_ok",   32'(crc_ok),   32'd0);
        check("midrst_crc_val",  32'(crc_val),  32'h0);
        rst_n = 1'b1;

        send_block("after_rst", 17, 32'h10000, 16'h1021, 1'b0, -1, 1'b1, 16'h1021);

`ifdef VDEC_HS_UEID_MASK_EN
        ue_id = 16'hABCD;
        send_block("ue_abcd", 8, 32'h0, 16'hABCD, 1'b0, -1, 1'b1, 16'h0000);
        send_block("ue_zero", 8, 32'h0, 16'h0000, 1'b0, -1, 1'b0, 16'h0000);
        ue_id = 16'h0000;
`else
        send_block("ue_abcd", 8, 32'h0, 16'hABCD, 1'b0, -1, 1'b0, 16'h0000);
        send_block("ue_zero", 8, 32'h0, 16'h0000, 1'b0, -1, 1'b1, 16'h0000);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
